// File: rtl/acc_sequencer_6_bit_if.sv
// Purpose : bundles the sequencer's operation handshake, adder drive/return and result handshake.
// Latency : none; wiring only.
// Backpr. : carries op_valid/op_ready and res_valid/res_ready; no buffering here.
// Ports   : slave modport = sequencer side, master modport = environment (op source, adder, consumer).
// Option  : ACC_OVF_FLAG_EN adds the 'of' signed-overflow flag.
interface acc_sequencer_6_bit_if #(
    parameter int WIDTH = 6
);
    logic             op_valid;
    logic             op_ready;
    logic [1:0]       op_code;
    logic [WIDTH-1:0] op_data;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_r;
    logic             add_cf;
    logic             add_sf;
    logic             add_zf;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res;
    logic             cf;
    logic             sf;
    logic             zf;
`ifdef ACC_OVF_FLAG_EN
    logic             of;
`endif

    modport slave (
        input  op_valid, op_code, op_data,
        input  add_r, add_cf, add_sf, add_zf,
        input  res_ready,
        output op_ready, add_a, add_b,
        output res_valid, res, cf, sf, zf
`ifdef ACC_OVF_FLAG_EN
        , output of
`endif
    );

    modport master (
        output op_valid, op_code, op_data,
        output add_r, add_cf, add_sf, add_zf,
        output res_ready,
        input  op_ready, add_a, add_b,
        input  res_valid, res, cf, sf, zf
`ifdef ACC_OVF_FLAG_EN
        , input of
`endif
    );
endinterface

// File: rtl/acc_sequencer_6_bit.sv
// Purpose : accumulator sequencer feeding a 6-bit adder; LOAD/ADD/ADC/SUB, ADC and SUB via a second "+1" pass.
// Latency : accept->res_valid LOAD 1, ADD 2, ADC(cf=0) 2, ADC(cf=1) 3, SUB 3 cycles.
// Backpr. : op_ready only in IDLE; result held in DONE until res_ready, then back to IDLE.
// Ports   : clk, rst (sync, active-high), bus (acc_sequencer_6_bit_if.slave).
// Option  : define ACC_OVF_FLAG_EN to add the registered signed-overflow flag bus.of.
module acc_sequencer_6_bit #(
    parameter int WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    acc_sequencer_6_bit_if.slave  bus
);
    localparam int MSB = WIDTH - 1;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_ADC  = 2'b10;
    localparam logic [1:0] OP_SUB  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC1 = 2'd1,
        EXEC2 = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       code_q, code_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             c1_q, c1_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             cf_q, cf_d;
    logic             sf_q, sf_d;
    logic             zf_q, zf_d;
    // add_a_q doubles as the first-pass sum register during EXEC2.
    logic [WIDTH-1:0] add_a_q, add_a_d;
    logic [WIDTH-1:0] add_b_q, add_b_d;
    logic             res_valid_q, res_valid_d;
`ifdef ACC_OVF_FLAG_EN
    logic             of_q, of_d;
    logic             ovf_add, ovf_sub;

    // acc_q and opnd_q still hold the original operands until the op completes,
    // so these are valid on whichever pass produces the final sum.
    assign ovf_add = (acc_q[MSB] == opnd_q[MSB]) && (bus.add_r[MSB] != acc_q[MSB]);
    assign ovf_sub = (acc_q[MSB] != opnd_q[MSB]) && (bus.add_r[MSB] != acc_q[MSB]);
`endif

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        opnd_d      = opnd_q;
        c1_d        = c1_q;
        acc_d       = acc_q;
        cf_d        = cf_q;
        sf_d        = sf_q;
        zf_d        = zf_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        res_valid_d = res_valid_q;
`ifdef ACC_OVF_FLAG_EN
        of_d        = of_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.op_valid) begin
                    code_d = bus.op_code;
                    opnd_d = bus.op_data;
                    if (bus.op_code == OP_LOAD) begin
                        acc_d       = bus.op_data;
                        cf_d        = 1'b0;
                        sf_d        = bus.op_data[MSB];
                        zf_d        = (bus.op_data == '0);
`ifdef ACC_OVF_FLAG_EN
                        of_d        = 1'b0;
`endif
                        res_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        // Adder inputs are registered so they are stable for the whole EXEC1 cycle.
                        add_a_d = acc_q;
                        add_b_d = (bus.op_code == OP_SUB) ? ~bus.op_data : bus.op_data;
                        state_d = EXEC1;
                    end
                end
            end
            EXEC1: begin
                c1_d = bus.add_cf;
                // ADC consults the cf captured before this op; cf_q is untouched until the op ends.
                if ((code_q == OP_ADD) || ((code_q == OP_ADC) && !cf_q)) begin
                    acc_d       = bus.add_r;
                    cf_d        = bus.add_cf;
                    sf_d        = bus.add_sf;
                    zf_d        = bus.add_zf;
`ifdef ACC_OVF_FLAG_EN
                    of_d        = ovf_add;
`endif
                    add_a_d     = '0;
                    add_b_d     = '0;
                    res_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    // Second pass adds the missing carry-in (ADC) or the two's-complement +1 (SUB).
                    add_a_d = bus.add_r;
                    add_b_d = WIDTH'(1);
                    state_d = EXEC2;
                end
            end
            EXEC2: begin
                acc_d       = bus.add_r;
                cf_d        = c1_q | bus.add_cf;
                sf_d        = bus.add_sf;
                zf_d        = bus.add_zf;
`ifdef ACC_OVF_FLAG_EN
                of_d        = (code_q == OP_SUB) ? ovf_sub : ovf_add;
`endif
                add_a_d     = '0;
                add_b_d     = '0;
                res_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            code_q      <= OP_LOAD;
            opnd_q      <= '0;
            c1_q        <= 1'b0;
            acc_q       <= '0;
            cf_q        <= 1'b0;
            sf_q        <= 1'b0;
            zf_q        <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            res_valid_q <= 1'b0;
`ifdef ACC_OVF_FLAG_EN
            of_q        <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            opnd_q      <= opnd_d;
            c1_q        <= c1_d;
            acc_q       <= acc_d;
            cf_q        <= cf_d;
            sf_q        <= sf_d;
            zf_q        <= zf_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            res_valid_q <= res_valid_d;
`ifdef ACC_OVF_FLAG_EN
            of_q        <= of_d;
`endif
        end
    end

    assign bus.op_ready  = (state_q == IDLE) && !rst;
    assign bus.add_a     = add_a_q;
    assign bus.add_b     = add_b_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res       = acc_q;
    assign bus.cf        = cf_q;
    assign bus.sf        = sf_q;
    assign bus.zf        = zf_q;
`ifdef ACC_OVF_FLAG_EN
    assign bus.of        = of_q;
`endif

endmodule

// File: tb/tb_acc_sequencer_6_bit.sv
// Purpose : self-checking bench for acc_sequencer_6_bit with an ideal 6-bit adder attached.
// Latency : n/a.
// Backpr. : exercises res_ready hold-off with op_valid noise while busy.
`timescale 1ns/1ps
module tb_acc_sequencer_6_bit;
    localparam int W = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    acc_sequencer_6_bit_if #(.WIDTH(W)) bus ();

    acc_sequencer_6_bit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Ideal combinational adder downstream of the sequencer.
    logic [W:0] sum7;
    assign sum7       = {1'b0, bus.add_a} + {1'b0, bus.add_b};
    assign bus.add_r  = sum7[W-1:0];
    assign bus.add_cf = sum7[W];
    assign bus.add_sf = sum7[W-1];
    assign bus.add_zf = (sum7[W-1:0] == '0);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_acc = 0, m_cf = 0, m_sf = 0, m_zf = 0;
    int p_acc, p_cf, p_sf, p_zf;
    int m_phase = 0;   // 0 idle, 1 busy, 2 result held
    int m_cnt   = 0;
    bit started = 0;
    bit fe_chk  = 0;
    int fe_a, fe_b;
`ifdef ACC_OVF_FLAG_EN
    int m_of = 0, p_of;
    int want_of = -1;
`endif

    function automatic int sx(input int x);
        return (x >= 32) ? x - 64 : x;
    endfunction

    task automatic model_apply();
        m_acc = p_acc; m_cf = p_cf; m_sf = p_sf; m_zf = p_zf;
`ifdef ACC_OVF_FLAG_EN
        m_of = p_of;
`endif
        m_phase = 2;
    endtask

    always @(posedge clk) begin
        int a, b, c, s, sv, lat;
        fe_chk = 0;
        if (rst) begin
            m_acc = 0; m_cf = 0; m_sf = 0; m_zf = 0; m_phase = 0;
`ifdef ACC_OVF_FLAG_EN
            m_of = 0;
`endif
        end else begin
            case (m_phase)
                0: if (bus.op_valid) begin
                    a = m_acc; b = int'(bus.op_data); sv = 0; lat = 1;
                    case (bus.op_code)
                        2'b00: begin p_acc = b; p_cf = 0; lat = 1; end
                        2'b01: begin s = a + b; p_acc = s % 64; p_cf = (s > 63);
                                     sv = sx(a) + sx(b); lat = 2; end
                        2'b10: begin c = m_cf; s = a + b + c; p_acc = s % 64; p_cf = (s > 63);
                                     sv = sx(a) + sx(b) + c; lat = c ? 3 : 2; end
                        default: begin p_acc = (a - b + 64) % 64; p_cf = (a >= b);
                                     sv = sx(a) - sx(b); lat = 3; end
                    endcase
                    p_sf = (p_acc >= 32);
                    p_zf = (p_acc == 0);
`ifdef ACC_OVF_FLAG_EN
                    p_of = (sv > 31 || sv < -32);
`endif
                    if (lat == 1) model_apply();
                    else begin
                        m_phase = 1; m_cnt = lat - 1; fe_chk = 1;
                        fe_a = a;
                        fe_b = (bus.op_code == 2'b11) ? (63 - b) : b;
                    end
                end
                1: begin
                    m_cnt--;
                    if (m_cnt == 0) model_apply();
                end
                default: if (bus.res_ready) m_phase = 0;
            endcase
        end
        started = 1;
    end

    // Cycle-by-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            check("op_ready", int'(bus.op_ready), int'(m_phase == 0 && !rst));
            check("res_valid", int'(bus.res_valid), int'(m_phase == 2));
            check("res", int'(bus.res), m_acc);
            check("cf", int'(bus.cf), m_cf);
            check("sf", int'(bus.sf), m_sf);
            check("zf", int'(bus.zf), m_zf);
`ifdef ACC_OVF_FLAG_EN
            check("of", int'(bus.of), m_of);
`endif
            if (m_phase != 1) begin
                check("add_a_idle", int'(bus.add_a), 0);
                check("add_b_idle", int'(bus.add_b), 0);
            end
            if (fe_chk) begin
                check("add_a_pass1", int'(bus.add_a), fe_a);
                check("add_b_pass1", int'(bus.add_b), fe_b);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // exp_* < 0 means "no literal expectation"; the model still checks every cycle.
    task automatic do_op(input logic [1:0] code, input logic [5:0] data, input int hold,
                         input int e_res, input int e_cf, input int e_sf, input int e_zf,
                         input int e_lat);
        int k, lat;
        k = 0;
        while (!bus.op_ready && k < 50) begin step(); k++; end
        check("op_ready_wait", int'(bus.op_ready), 1);
        bus.op_valid = 1'b1;
        bus.op_code  = code;
        bus.op_data  = data;
        step();
        bus.op_valid = 1'b0;
        lat = 1;
        while (!bus.res_valid && lat < 8) begin step(); lat++; end
        check("res_valid_timeout", int'(bus.res_valid), 1);
        if (e_lat >= 0) check("latency", lat, e_lat);
        if (e_res >= 0) check("lit_res", int'(bus.res), e_res);
        if (e_cf  >= 0) check("lit_cf",  int'(bus.cf),  e_cf);
        if (e_sf  >= 0) check("lit_sf",  int'(bus.sf),  e_sf);
        if (e_zf  >= 0) check("lit_zf",  int'(bus.zf),  e_zf);
`ifdef ACC_OVF_FLAG_EN
        if (want_of >= 0) check("lit_of", int'(bus.of), want_of);
`endif
        for (int i = 0; i < hold; i++) begin
            bus.op_valid = 1'($urandom_range(0, 1));
            bus.op_code  = 2'($urandom);
            bus.op_data  = 6'($urandom);
            step();
        end
        if (hold > 0 && e_res >= 0) begin
            check("hold_res", int'(bus.res), e_res);
            check("hold_op_ready", int'(bus.op_ready), 0);
        end
        bus.op_valid  = 1'b0;
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
    endtask

    initial begin
        int k;
        bus.op_valid  = 1'b0;
        bus.op_code   = 2'b00;
        bus.op_data   = '0;
        bus.res_ready = 1'b0;
        rst = 1'b1;

        // T1 reset
        step(); step();
        check("t1_res", int'(bus.res), 0);
        check("t1_res_valid", int'(bus.res_valid), 0);
        check("t1_op_ready_in_rst", int'(bus.op_ready), 0);
        rst = 1'b0;
        #1;
        check("t1_op_ready_after", int'(bus.op_ready), 1);

        // T2
        do_op(2'b00, 6'h2A, 0, 'h2A, 0, 1, 0, 1);
        do_op(2'b01, 6'h17, 0, 'h01, 1, 0, 0, 2);
        // T3
        do_op(2'b00, 6'h05, 0, 'h05, 0, 0, 0, 1);
        do_op(2'b11, 6'h05, 0, 'h00, 1, 0, 1, 3);
        do_op(2'b11, 6'h01, 0, 'h3F, 0, 1, 0, 3);
        // T4
        do_op(2'b00, 6'h3F, 0, 'h3F, 0, 1, 0, 1);
        do_op(2'b01, 6'h01, 0, 'h00, 1, 0, 1, 2);
        do_op(2'b10, 6'h00, 0, 'h01, 0, 0, 0, 3);
        do_op(2'b10, 6'h00, 0, 'h01, 0, 0, 0, 2);
        // T5 backpressure with op_valid noise
        do_op(2'b00, 6'h15, 4, 'h15, 0, 0, 0, 1);
        do_op(2'b11, 6'h20, 4, 'h35, 0, 1, 0, 3);

        // T6 reset during second pass of SUB
        do_op(2'b00, 6'h10, 0, 'h10, 0, 0, 0, 1);
        k = 0;
        while (!bus.op_ready && k < 50) begin step(); k++; end
        bus.op_valid = 1'b1;
        bus.op_code  = 2'b11;
        bus.op_data  = 6'h03;
        step();
        bus.op_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        check("t6_res", int'(bus.res), 0);
        check("t6_res_valid", int'(bus.res_valid), 0);
        rst = 1'b0;
        #1;
        check("t6_op_ready", int'(bus.op_ready), 1);
        repeat (4) step();

`ifdef ACC_OVF_FLAG_EN
        // T7
        want_of = 0;
        do_op(2'b00, 6'h1F, 0, 'h1F, 0, 0, 0, 1);
        want_of = 1;
        do_op(2'b01, 6'h01, 0, 'h20, 0, 1, 0, 2);
        want_of = 0;
        do_op(2'b00, 6'h20, 0, 'h20, 0, 1, 0, 1);
        want_of = 1;
        do_op(2'b11, 6'h01, 0, 'h1F, 1, 0, 0, 3);
        want_of = -1;
`endif

        // Randomized operations checked by the model.
        for (int n = 0; n < 200; n++) begin
            do_op(2'($urandom), 6'($urandom), int'($urandom_range(0, 3)), -1, -1, -1, -1, -1);
        end
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
